// File: rtl/program_loader.sv
// program_loader: writer side of the 32-word instruction memory.
// Accepts a length header followed by big-endian 32-bit words on a
// valid/ready byte stream. Each word goes to the next sequential address,
// and the core is held in reset until the whole image is loaded.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, the loader
// expects one trailing byte after the image, equal to the XOR of all data bytes.
module program_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              chk_err
);

  localparam int          CNT_W   = ADDR_W + 1;
  localparam logic [31:0] DEPTH_U = 32'(1 << ADDR_W);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_BYTE, S_WRITE, S_CHK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_BYTE, S_WRITE, S_DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;           // words in the image (1..DEPTH)
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d; // one bit wider so L==DEPTH never wraps
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         word_q, word_d;         // first three bytes of the word being assembled
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                len_err_q, len_err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
  logic                chk_err_q, chk_err_d;
`endif

  logic xfer;
  assign xfer = byte_valid && byte_ready;

  // Status outputs are pure functions of the state.
`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_LEN) || (state_q == S_BYTE) || (state_q == S_CHK);
  assign busy       = (state_q == S_LEN) || (state_q == S_BYTE) ||
                      (state_q == S_WRITE) || (state_q == S_CHK);
  assign chk_err    = chk_err_q;
`else
  assign byte_ready = (state_q == S_LEN) || (state_q == S_BYTE);
  assign busy       = (state_q == S_LEN) || (state_q == S_BYTE) || (state_q == S_WRITE);
  assign chk_err    = 1'b0;
`endif
  assign imem_we    = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign core_reset = (state_q != S_DONE);
  assign imem_addr  = addr_q;
  assign imem_data  = data_q;
  assign len_err    = len_err_q;

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      len_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      len_err_q  <= len_err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

  // Next-state logic: header decode, word assembly, write sequencing.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    data_d     = data_q;
    len_err_d  = len_err_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
    chk_err_d  = chk_err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LEN;
          len_err_d  = 1'b0;
          word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_err_d  = 1'b0;
          xor_d      = '0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (byte_in == 8'd0) begin
            state_d = S_DONE;
          end else if (32'(byte_in) > DEPTH_U) begin
            len_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d      = CNT_W'(byte_in);
            byte_cnt_d = '0;
            state_d    = S_BYTE;
          end
        end
      end
      S_BYTE: begin
        if (xfer) begin
          word_d     = {word_q[15:0], byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ byte_in;
`endif
          if (byte_cnt_q == 2'd3) begin
            addr_d  = word_cnt_q[ADDR_W-1:0];
            data_d  = {word_q, byte_in};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (word_cnt_q == len_q - CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          byte_cnt_d = '0;
          state_d    = S_BYTE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (byte_in == xor_q) begin
            state_d = S_DONE;
          end else begin
            chk_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule
